// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle control unit with a small internal register file.
// Each accepted instruction is latched and sequenced through decode, execute,
// an optional memory access and an optional write-back. The datapath
// (ALU and data memory) is external to this block.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   instr_valid_i  instruction offered
//   instr_i        {type[2], rd, rs1, rs2, offset[DATA_WIDTH], opcode[4]}
//   instr_ready_o  high only in IDLE while out of reset
//   result2_i      ALU result / memory read data for write-back
//   mem_ready_i    data memory has completed the current access
//   operand1_o     reg[rs1]
//   operand2_o     reg[rs2] (ALU) or reg[rd] (LDR/STR)
//   offset_o       instruction offset
//   opcode_o       ALU opcode
//   sel1_o         ALU-result path select
//   sel3_o         offset path select
//   w_r_o          memory write enable
//   busy_o         state != IDLE
//   retire_o       one-cycle pulse per completed instruction
//
// state      | meaning
// IDLE       | waiting for an instruction; NOPs retire here directly
// DECODE     | read register file, load operand/select outputs
// EXECUTE    | pick memory or write-back path; STR raises w_r
// MEM_ACCESS | hold outputs until mem_ready
// WRITE_BACK | reg[rd] <= result2, retire
module cu_multicycle #(
  parameter int DATA_WIDTH    = 8,
  parameter int REG_ADDR_BITS = 2,
  localparam int INSTR_WIDTH  = 2 + 3*REG_ADDR_BITS + DATA_WIDTH + 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_valid_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic                   instr_ready_o,
  input  logic [DATA_WIDTH-1:0]  result2_i,
  input  logic                   mem_ready_i,
  output logic [DATA_WIDTH-1:0]  operand1_o,
  output logic [DATA_WIDTH-1:0]  operand2_o,
  output logic [DATA_WIDTH-1:0]  offset_o,
  output logic [3:0]             opcode_o,
  output logic                   sel1_o,
  output logic                   sel3_o,
  output logic                   w_r_o,
  output logic                   busy_o,
  output logic                   retire_o
);

  localparam int NREGS    = 2**REG_ADDR_BITS;
  localparam int OFF_LSB  = 4;
  localparam int RS2_LSB  = OFF_LSB + DATA_WIDTH;
  localparam int RS1_LSB  = RS2_LSB + REG_ADDR_BITS;
  localparam int RD_LSB   = RS1_LSB + REG_ADDR_BITS;
  localparam int TYPE_LSB = RD_LSB + REG_ADDR_BITS;

  localparam logic [1:0] T_NOP = 2'b00;
  localparam logic [1:0] T_ALU = 2'b01;
  localparam logic [1:0] T_STR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0]  regs_q [NREGS];
  logic [DATA_WIDTH-1:0]  regs_d [NREGS];
  logic [DATA_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d, off_q, off_d;
  logic [3:0]             opc_q, opc_d;
  logic                   sel1_q, sel1_d, sel3_q, sel3_d, wr_q, wr_d, retire_q, retire_d;

  logic [1:0]               type_w;
  logic [REG_ADDR_BITS-1:0] rd_w, rs1_w, rs2_w;
  logic                     accept_w;

  assign type_w = instr_q[TYPE_LSB +: 2];
  assign rd_w   = instr_q[RD_LSB +: REG_ADDR_BITS];
  assign rs1_w  = instr_q[RS1_LSB +: REG_ADDR_BITS];
  assign rs2_w  = instr_q[RS2_LSB +: REG_ADDR_BITS];

  assign instr_ready_o = (state_q == S_IDLE) && rst_ni;
  assign busy_o        = (state_q != S_IDLE);
  assign accept_w      = instr_valid_i && instr_ready_o;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    regs_d   = regs_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    off_d    = off_q;
    opc_d    = opc_q;
    sel1_d   = sel1_q;
    sel3_d   = sel3_q;
    wr_d     = wr_q;
    retire_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_w) begin
          instr_d = instr_i;
          if (instr_i[TYPE_LSB +: 2] == T_NOP) retire_d = 1'b1;
          else                                 state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        op1_d = regs_q[rs1_w];
        off_d = instr_q[OFF_LSB +: DATA_WIDTH];
        opc_d = instr_q[3:0];
        wr_d  = 1'b0;
        if (type_w == T_ALU) begin
          op2_d  = regs_q[rs2_w];
          sel1_d = 1'b1;
          sel3_d = 1'b0;
        end else begin
          op2_d  = regs_q[rd_w];
          sel1_d = 1'b0;
          sel3_d = 1'b1;
        end
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (type_w == T_ALU) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
          if (type_w == T_STR) wr_d = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready_i) begin
          if (type_w == T_STR) begin
            wr_d     = 1'b0;
            retire_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (type_w != T_STR) regs_d[rd_w] = result2_i;
        retire_d = 1'b1;
        state_d  = S_IDLE;
      end
      // Unreachable encodings recover to IDLE without touching the register file.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_WIDTH'(i);
      op1_q    <= '0;
      op2_q    <= '0;
      off_q    <= '0;
      opc_q    <= 4'hF;
      sel1_q   <= 1'b0;
      sel3_q   <= 1'b0;
      wr_q     <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      regs_q   <= regs_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      off_q    <= off_d;
      opc_q    <= opc_d;
      sel1_q   <= sel1_d;
      sel3_q   <= sel3_d;
      wr_q     <= wr_d;
      retire_q <= retire_d;
    end
  end

  assign operand1_o = op1_q;
  assign operand2_o = op2_q;
  assign offset_o   = off_q;
  assign opcode_o   = opc_q;
  assign sel1_o     = sel1_q;
  assign sel3_o     = sel3_q;
  assign w_r_o      = wr_q;
  assign retire_o   = retire_q;

endmodule

// File: tb/tb_cu_multicycle.sv
module tb_cu_multicycle;
  localparam int DW = 8;
  localparam int IW = 20;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic [IW-1:0] instr = '0;
  logic          instr_ready;
  logic [DW-1:0] result2 = '0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] operand1, operand2, offset;
  logic [3:0]    opcode;
  logic          sel1, sel3, w_r, busy, retire;

  cu_multicycle dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_i(instr),
    .instr_ready_o(instr_ready), .result2_i(result2), .mem_ready_i(mem_ready),
    .operand1_o(operand1), .operand2_o(operand2), .offset_o(offset), .opcode_o(opcode),
    .sel1_o(sel1), .sel3_o(sel3), .w_r_o(w_r), .busy_o(busy), .retire_o(retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] op1, op2, off;
    logic [3:0] opc;
    logic       sel1, sel3;
    int         busy_cyc, wr_cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] regs_m [NR];
  exp_t       last_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) regs_m[i] = 8'(i);
    last_m.op1 = '0; last_m.op2 = '0; last_m.off = '0; last_m.opc = 4'hF;
    last_m.sel1 = 1'b0; last_m.sel3 = 1'b0;
  endtask

  // Issues one instruction at a negedge; returns at a negedge once it has retired.
  task automatic issue(input logic [1:0] ty, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] off, input logic [3:0] opc,
                       input int w, input logic [7:0] res, input bit garbage);
    exp_t e;
    int   guard = 0;
    while (!instr_ready) begin
      @(negedge clk);
      if (++guard > 50) begin timeout_fail("ready_wait"); return; end
    end
    e = last_m;
    e.busy_cyc = 0;
    e.wr_cyc = 0;
    if (ty != 2'b00) begin
      e.op1 = regs_m[rs1];
      e.op2 = (ty == 2'b01) ? regs_m[rs2] : regs_m[rd];
      e.off = off;
      e.opc = opc;
      e.sel1 = (ty == 2'b01);
      e.sel3 = (ty != 2'b01);
      e.busy_cyc = (ty == 2'b01) ? 3 : (ty == 2'b10) ? 4 + w : 3 + w;
      e.wr_cyc = (ty == 2'b11) ? w + 1 : 0;
      if (ty != 2'b11) regs_m[rd] = res;
      last_m = e;
    end
    sb_q.push_back(e);
    instr_valid = 1'b1;
    instr = {ty, rd, rs1, rs2, off, opc};
    result2 = res;
    mem_ready = 1'b0;
    @(negedge clk);
    if (ty == 2'b00) begin
      instr_valid = 1'b0;
      return;
    end
    instr_valid = garbage;
    if (garbage) instr = IW'($urandom);
    for (int c = 1; c <= w + 2; c++) begin
      @(negedge clk);
      if (c == 2) instr_valid = 1'b0;
    end
    mem_ready = 1'b1;
    guard = 0;
    while (busy) begin
      @(negedge clk);
      if (++guard > 50) begin timeout_fail("retire_wait"); break; end
    end
    mem_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every retire pulse.
  initial begin
    int   busy_cnt = 0;
    int   wr_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (w_r) wr_cnt++;
        if (retire) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_retire: got retire=1 expected no retire");
          end else begin
            e = sb_q.pop_front();
            check("operand1", operand1, e.op1);
            check("operand2", operand2, e.op2);
            check("offset", offset, e.off);
            check("opcode", opcode, e.opc);
            check("sel1", sel1, e.sel1);
            check("sel3", sel3, e.sel3);
            check("w_r_at_retire", w_r, 0);
            check("busy_cycles", busy_cnt, e.busy_cyc);
            check("w_r_cycles", wr_cnt, e.wr_cyc);
          end
          busy_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ty, rd, rs1, rs2;
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("ready_in_reset", instr_ready, 0);
    @(negedge clk);
    check("rst_operand1", operand1, 0);
    check("rst_operand2", operand2, 0);
    check("rst_offset", offset, 0);
    check("rst_opcode", opcode, 4'hF);
    check("rst_sel_wr", {sel1, sel3, w_r, retire, busy}, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", instr_ready, 1);
    @(negedge clk);

    issue(2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 4'h2, 0, 8'h05, 1'b1);
    issue(2'b10, 2'd0, 2'd2, 2'd0, 8'h14, 4'h0, 3, 8'hAA, 1'b1);
    issue(2'b11, 2'd1, 2'd2, 2'd0, 8'h20, 4'h0, 1, 8'h3C, 1'b1);
    issue(2'b01, 2'd1, 2'd3, 2'd0, 8'h00, 4'h1, 0, 8'h5A, 1'b0);
    issue(2'b00, 2'd2, 2'd1, 2'd3, 8'h7E, 4'h9, 0, 8'hEE, 1'b0);
    issue(2'b00, 2'd0, 2'd0, 2'd0, 8'h00, 4'h0, 0, 8'h00, 1'b0);

    // Reset landing on the write-back edge of an ALU write to reg2.
    instr_valid = 1'b1;
    instr = {2'b01, 2'd2, 2'd0, 2'd1, 8'h00, 4'h3};
    result2 = 8'h77;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_in_wb", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_retire", retire, 0);
    check("abort_busy", busy, 0);
    check("abort_opcode", opcode, 4'hF);
    check("abort_ready", instr_ready, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    issue(2'b01, 2'd0, 2'd2, 2'd3, 8'h00, 4'h4, 0, 8'h11, 1'b0);

    for (int n = 0; n < 60; n++) begin
      ty  = 2'($urandom_range(0, 3));
      rd  = 2'($urandom_range(0, 3));
      rs1 = 2'($urandom_range(0, 3));
      rs2 = 2'($urandom_range(0, 3));
      issue(ty, rd, rs1, rs2, 8'($urandom), 4'($urandom), int'($urandom_range(0, 4)),
            8'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cu_multicycle.md
CU_MULTICYCLE -- requirements
Module: cu_multicycle

Interface
REQ-001 DATA_WIDTH, 8, register/operand/offset width in bits; SHALL be >= 2.
REQ-002 REG_ADDR_BITS, 2, register-index width; the register file SHALL hold 2**REG_ADDR_BITS entries.
REQ-003 INSTR_WIDTH, derived, SHALL equal 2+3*REG_ADDR_BITS+DATA_WIDTH+4 (20 at defaults) and SHALL not be overridable.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 instr_valid  in  1  instruction offered.
REQ-007 instr  in  INSTR_WIDTH  fields MSB->LSB: type[2], rd, rs1, rs2 (REG_ADDR_BITS each), offset[DATA_WIDTH], opcode[4].
REQ-008 instr_ready  out  1  SHALL be 1 only in IDLE with rst high (combinational).
REQ-009 result2  in  DATA_WIDTH  ALU result / memory read data for write-back.
REQ-010 mem_ready  in  1  data memory has completed the current access.
REQ-011 operand1, operand2, offset  out  DATA_WIDTH each, registered.
REQ-012 opcode  out  4, registered ALU opcode.
REQ-013 sel1, sel3, w_r  out  1 each, registered (sel1=ALU-result path, sel3=offset path, w_r=memory write enable).
REQ-014 busy  out  1  SHALL equal (state != IDLE), combinational.
REQ-015 retire  out  1  registered one-cycle pulse per completed instruction.

Function
REQ-016 Types: 00 NOP, 01 ALU (rd<=f(rs1,rs2)), 10 LDR (rd<=mem[rs1+offset]), 11 STR (mem[rs1+offset]<=rd).
REQ-017 States: IDLE, DECODE, EXECUTE, MEM_ACCESS, WRITE_BACK; any other encoding SHALL go to IDLE on the next edge with no register-file write.
REQ-018 IDLE: on instr_valid&&instr_ready, instr SHALL be latched internally; type 00 -> stay IDLE, retire pulses; else -> DECODE; instr/instr_valid SHALL be ignored outside IDLE.
REQ-019 DECODE: load operand1=reg[rs1], offset, opcode; ALU: operand2=reg[rs2], sel1=1, sel3=0; LDR/STR: operand2=reg[rd], sel1=0, sel3=1; w_r=0; -> EXECUTE.
REQ-020 EXECUTE: ALU -> WRITE_BACK; LDR -> MEM_ACCESS; STR -> MEM_ACCESS with w_r<=1.
REQ-021 MEM_ACCESS: outputs SHALL hold while mem_ready=0 (unbounded wait); on mem_ready=1: LDR -> WRITE_BACK; STR -> w_r<=0, retire pulse, -> IDLE.
REQ-022 WRITE_BACK: reg[rd]<=result2 (ALU, LDR), retire pulse, -> IDLE; operand/select outputs SHALL hold.
REQ-023 Latency from acceptance edge T: ALU write at T+3; LDR write at T+3+W+1, where W = cycles mem_ready low in MEM_ACCESS; STR w_r high edges T+2..T+3+W; next acceptance earliest at the edge after retirement.
REQ-024 Register reads SHALL see all earlier writes (sequential execution; no bypass needed); rd=rs1 SHALL read the old value in DECODE.
REQ-025 Only rd SHALL be written, and only in WRITE_BACK.

Reset
REQ-026 rst=0 at an edge SHALL force: state IDLE; reg[i]=i truncated to DATA_WIDTH; operand1/operand2/offset=0; opcode=4'hF; sel1=sel3=w_r=0; retire=0.
REQ-027 Reset SHALL take priority in every state: aborts in-flight instruction, no write in a concurrent WRITE_BACK, w_r drops at that edge.

Verification
REQ-028 Hold rst=0 2 cycles -> reg0..3=0,1,2,3; opcode=F; outputs 0; instr_ready=0 during reset, 1 after.
REQ-029 ALU 01_11_01_10_00000000_0010 -> DECODE gives operand1=1, operand2=2, opcode=2, sel1=1, sel3=0; result2=05 at WRITE_BACK -> reg3=05, retire one cycle; next ALU reading rs1=3 gives operand1=05.
REQ-030 LDR 10_00_10_00_00010100_0000, mem_ready low 3 cycles, result2=AA -> operand1=2, offset=14h, sel1=0, sel3=1, MEM_ACCESS held 3 cycles, reg0=AA.
REQ-031 STR 11_01_10_00_00100000_0000, mem_ready low 1 cycle -> operand2=1, offset=20h, w_r high 2 cycles then 0; no register changes; retire once.
REQ-032 NOP (type 00) -> retire pulses, busy stays 0; instr_valid pulse while busy -> ignored, no effect.
REQ-033 Reset asserted during WRITE_BACK of ALU to rd=2 with result2=77 -> reg2=2 after reset, state IDLE.
